slice_pix_packer: RTL and testbench
===================================

// Module: slice_pix_packer
// PURPOSE
// - Consumes the raster pixel stream produced by the decoder slice mux (4 pixels/beat, lane mask,
//   sof/eol/eof markers) and repacks it into dense 4-pixel words for the display output stage.
// - Removes the lane bubbles left by partial last blocks at every slice boundary, checks line and
//   frame geometry, and raises sticky error flags. Runs entirely in clk_out_int.
// PARAMETERS
// - PIX_WIDTH  14  bits per colour component; word = 4 pixels x 3 comps; pix p comp c at [(p*3+c)*PIX_WIDTH +: PIX_WIDTH]
// - CNT_W      16  width of pixel-per-line and line-per-frame counters
// PORTS
// - clk_out_int    in   1           output pixel clock
// - rst_n          in   1           asynchronous, active-low reset
// - flush          in   1           synchronous clear of all state (same effect as reset)
// - line_width     in   CNT_W       expected pixels per line (static during frame)
// - frame_height   in   CNT_W       expected lines per frame (static during frame)
// - pixs_in        in   12*PIX_WIDTH input beat, lanes 0..3
// - pixs_in_valid  in   4           lane mask; legal values 0000,0001,0011,0111,1111
// - pixs_in_sof    in   1           start-of-frame marker pulse
// - pixs_in_eol    in   1           end-of-line marker; may coincide with a valid beat or be alone
// - pixs_in_eof    in   1           end-of-frame marker; always coincides with pixs_in_eol
// - pk_out         out  12*PIX_WIDTH packed word
// - pk_out_valid   out  4           lane mask; 1111 except final word of a line (thermometer)
// - pk_out_sof     out  1           one-cycle pulse, 1 cycle after pixs_in_sof
// - pk_out_eol     out  1           on the final word of each line
// - pk_out_eof     out  1           on the final word of the frame (with pk_out_eol)
// - width_err / height_err / mask_err / ovf_err  out 1 each  sticky error flags
// BEHAVIOUR
// - Reset/flush: all outputs 0, residual count 0, hold register empty, counters 0, errors 0.
// - Residual buffer: up to 3 pixels (res_cnt 0..3). Per processed beat n = number of trailing ones
//   of the mask; total = res_cnt + n. Pixel order is residual first, then incoming lanes low->high.
// - total >= 4: emit full word (valid 1111) next cycle; res_cnt <= total-4 keeps upper input lanes.
// - total < 4 and no eol: no output; residual absorbs the lanes.
// - eol with total in 1..4: emit total pixels, mask thermometer(total), pk_out_eol=1; res_cnt <= 0.
// - eol with total in 5..7: emit 4 pixels now (no eol); next cycle emit total-4 with pk_out_eol.
//   This flush cycle is a stall: a beat arriving in it is captured in a 1-deep hold register.
// - eol with total 0: emit a word with valid 0000 and pk_out_eol=1 (marker-only word).
// - Hold register: while occupied the processed beat is the held one and the new input (if any)
//   replaces it; drains on first cycle with no input. Input arriving while hold occupied AND a new
//   stall is required -> beat dropped, ovf_err=1.
// - Latency: 1 cycle input->pk_out, +1 per outstanding stall until hold drains.
// - sof: highest priority; discards residual and hold, clears pixel/line counters and all error
//   flags, pk_out_sof=1 next cycle; any lanes on the sof cycle are discarded.
// - Non-thermometer mask: lanes above the first 0 discarded, mask_err=1.
// - Geometry: pixel counter += emitted pixels; at each emitted eol, count != line_width ->
//   width_err=1; counter cleared. Line counter increments per eol; at eof, lines != frame_height ->
//   height_err=1. pk_out_eof is asserted with the final eol word, including a flush-cycle word.
// - Counters wrap silently at 2^CNT_W; errors remain sticky until sof, flush or reset.
// - pk_out data lanes beyond pk_out_valid are don't-care; no backpressure (downstream always accepts).
// TESTING
// - sof; line_width=10; beats 1111,1111,0011+eol -> 1 cycle later 1111,1111,0011+eol; errors 0.
// - line_width=16; beats 1111,0111,1111,1111,0001+eol -> four 1111 words; word1 = in1 lanes0-2 +
//   in2 lane0; last word has eol; width_err 0.
// - res_cnt=3 then 1111+eol, next-cycle beat 1111 -> word 1111, then 0111+eol, then held beat
//   emerges 1 cycle late in order; ovf_err 0.
// - frame_height=2, line_width=4: two lines, second with eof -> pk_out_eof on last word;
//   repeat with frame_height=3 -> height_err=1 after eof.
// - mask 0101 -> one pixel accepted, mask_err=1; next sof clears it.
// - flush (or rst_n low) mid-line with res_cnt=2 -> all outputs 0, residual lost, next sof starts clean.

Source files
------------

// File: rtl/slice_pix_packer_if.sv
// Pixel stream bundle between the slice mux and the packer, and from the packer to the display stage.
interface slice_pix_packer_if #(
    parameter int PIX_WIDTH = 14
);
    logic [12*PIX_WIDTH-1:0] pixs_in;
    logic [3:0]              pixs_in_valid;
    logic                    pixs_in_sof;
    logic                    pixs_in_eol;
    logic                    pixs_in_eof;

    logic [12*PIX_WIDTH-1:0] pk_out;
    logic [3:0]              pk_out_valid;
    logic                    pk_out_sof;
    logic                    pk_out_eol;
    logic                    pk_out_eof;

    modport master (
        output pixs_in, pixs_in_valid, pixs_in_sof, pixs_in_eol, pixs_in_eof,
        input  pk_out, pk_out_valid, pk_out_sof, pk_out_eol, pk_out_eof
    );

    modport slave (
        input  pixs_in, pixs_in_valid, pixs_in_sof, pixs_in_eol, pixs_in_eof,
        output pk_out, pk_out_valid, pk_out_sof, pk_out_eol, pk_out_eof
    );
endinterface

// File: rtl/slice_pix_packer.sv
// Repacks the 4-lane masked raster stream into dense 4-pixel words, closing lane bubbles at
// line ends, and checks line/frame geometry with sticky error flags.
module slice_pix_packer #(
    parameter int PIX_WIDTH = 14,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_out_int,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [CNT_W-1:0]     line_width,
    input  logic [CNT_W-1:0]     frame_height,
    slice_pix_packer_if.slave    bus,
    output logic                 width_err,
    output logic                 height_err,
    output logic                 mask_err,
    output logic                 ovf_err
);
    localparam int PXW = 3 * PIX_WIDTH;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    typedef struct packed {
        logic [3:0][PXW-1:0] out_pix;
        logic [3:0]          out_valid;
        logic                out_sof;
        logic                out_eol;
        logic                out_eof;
        logic [2:0][PXW-1:0] res;
        logic [1:0]          res_cnt;
        logic [2:0][PXW-1:0] pend;
        logic [1:0]          pend_cnt;
        logic                pend_eof;
        logic                hold_vld;
        logic [3:0][PXW-1:0] hold_pix;
        logic [3:0]          hold_mask;
        logic                hold_eol;
        logic                hold_eof;
        logic [CNT_W-1:0]    pix_cnt;
        logic [CNT_W-1:0]    line_cnt;
        logic                width_err;
        logic                height_err;
        logic                mask_err;
        logic                ovf_err;
    } st_t;

    state_t state_reg, state_next;
    st_t    st_reg, st_next;

    function automatic logic [2:0] lead_ones(input logic [3:0] m);
        if (!m[0])      return 3'd0;
        else if (!m[1]) return 3'd1;
        else if (!m[2]) return 3'd2;
        else if (!m[3]) return 3'd3;
        else            return 3'd4;
    endfunction

    function automatic logic [3:0] therm(input logic [2:0] n);
        case (n)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    logic [3:0][PXW-1:0] in_pix;
    logic                beat_in;
    logic                proc;
    logic [3:0][PXW-1:0] p_pix;
    logic [3:0]          p_mask;
    logic                p_eol, p_eof;
    logic [2:0]          n, total, rem;
    logic [6:0][PXW-1:0] cat;
    logic                emit, emit_eol, emit_eof;
    logic [2:0]          emit_n;
    logic [3:0][PXW-1:0] emit_pix;
    logic [CNT_W-1:0]    line_px, lines;
    int                  k;

    assign in_pix  = bus.pixs_in;
    assign beat_in = (|bus.pixs_in_valid) | bus.pixs_in_eol | bus.pixs_in_eof;

    always_comb begin
        st_next    = st_reg;
        state_next = state_reg;
        st_next.out_valid = 4'b0000;
        st_next.out_sof   = 1'b0;
        st_next.out_eol   = 1'b0;
        st_next.out_eof   = 1'b0;
        proc     = 1'b0;
        p_pix    = '0;
        p_mask   = '0;
        p_eol    = 1'b0;
        p_eof    = 1'b0;
        n        = '0;
        total    = '0;
        rem      = '0;
        cat      = '0;
        k        = 0;
        emit     = 1'b0;
        emit_eol = 1'b0;
        emit_eof = 1'b0;
        emit_n   = '0;
        emit_pix = st_reg.out_pix;
        line_px  = '0;
        lines    = '0;

        if (bus.pixs_in_sof) begin
            st_next.res_cnt    = '0;
            st_next.hold_vld   = 1'b0;
            st_next.pix_cnt    = '0;
            st_next.line_cnt   = '0;
            st_next.width_err  = 1'b0;
            st_next.height_err = 1'b0;
            st_next.mask_err   = 1'b0;
            st_next.ovf_err    = 1'b0;
            st_next.out_sof    = 1'b1;
            state_next         = ST_RUN;
        end else if (state_reg == ST_FLUSH) begin
            // Remainder of an over-long line end; the incoming beat parks in the hold register.
            emit       = 1'b1;
            emit_pix   = {{PXW{1'b0}}, st_reg.pend};
            emit_n     = {1'b0, st_reg.pend_cnt};
            emit_eol   = 1'b1;
            emit_eof   = st_reg.pend_eof;
            state_next = ST_RUN;
            if (beat_in) begin
                if (st_reg.hold_vld) begin
                    st_next.ovf_err = 1'b1;
                end else begin
                    st_next.hold_vld  = 1'b1;
                    st_next.hold_pix  = in_pix;
                    st_next.hold_mask = bus.pixs_in_valid;
                    st_next.hold_eol  = bus.pixs_in_eol;
                    st_next.hold_eof  = bus.pixs_in_eof;
                end
            end
        end else begin
            if (st_reg.hold_vld) begin
                proc   = 1'b1;
                p_pix  = st_reg.hold_pix;
                p_mask = st_reg.hold_mask;
                p_eol  = st_reg.hold_eol;
                p_eof  = st_reg.hold_eof;
                st_next.hold_vld  = beat_in;
                st_next.hold_pix  = in_pix;
                st_next.hold_mask = bus.pixs_in_valid;
                st_next.hold_eol  = bus.pixs_in_eol;
                st_next.hold_eof  = bus.pixs_in_eof;
            end else if (beat_in) begin
                proc   = 1'b1;
                p_pix  = in_pix;
                p_mask = bus.pixs_in_valid;
                p_eol  = bus.pixs_in_eol;
                p_eof  = bus.pixs_in_eof;
            end

            if (proc) begin
                n = lead_ones(p_mask);
                if (p_mask != therm(n))
                    st_next.mask_err = 1'b1;
                total = {1'b0, st_reg.res_cnt} + n;
                rem   = total - 3'd4;
                // Residual pixels first, then the accepted input lanes in order.
                for (int i = 0; i < 7; i++) begin
                    k = i - int'(st_reg.res_cnt);
                    if (i < int'(st_reg.res_cnt))
                        cat[i] = st_reg.res[i[1:0]];
                    else if (k < 4)
                        cat[i] = p_pix[k[1:0]];
                end

                if (p_eol && total > 3'd4) begin
                    emit             = 1'b1;
                    emit_pix         = cat[3:0];
                    emit_n           = 3'd4;
                    st_next.pend     = cat[6:4];
                    st_next.pend_cnt = rem[1:0];
                    st_next.pend_eof = p_eof;
                    st_next.res_cnt  = '0;
                    state_next       = ST_FLUSH;
                end else if (p_eol) begin
                    emit             = 1'b1;
                    emit_pix         = cat[3:0];
                    emit_n           = total;
                    emit_eol         = 1'b1;
                    emit_eof         = p_eof;
                    st_next.res_cnt  = '0;
                end else if (total >= 3'd4) begin
                    emit             = 1'b1;
                    emit_pix         = cat[3:0];
                    emit_n           = 3'd4;
                    st_next.res      = cat[6:4];
                    st_next.res_cnt  = rem[1:0];
                end else begin
                    st_next.res      = cat[2:0];
                    st_next.res_cnt  = total[1:0];
                end
            end
        end

        if (emit) begin
            st_next.out_pix   = emit_pix;
            st_next.out_valid = therm(emit_n);
            st_next.out_eol   = emit_eol;
            st_next.out_eof   = emit_eof;
            line_px = st_reg.pix_cnt + CNT_W'(emit_n);
            lines   = st_reg.line_cnt + CNT_W'(1);
            if (emit_eol) begin
                if (line_px != line_width)
                    st_next.width_err = 1'b1;
                st_next.pix_cnt = '0;
                if (emit_eof) begin
                    if (lines != frame_height)
                        st_next.height_err = 1'b1;
                    st_next.line_cnt = '0;
                end else begin
                    st_next.line_cnt = lines;
                end
            end else begin
                st_next.pix_cnt = line_px;
            end
        end

        if (flush) begin
            st_next    = '0;
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk_out_int or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            st_reg    <= '0;
        end else begin
            state_reg <= state_next;
            st_reg    <= st_next;
        end
    end

    assign bus.pk_out       = st_reg.out_pix;
    assign bus.pk_out_valid = st_reg.out_valid;
    assign bus.pk_out_sof   = st_reg.out_sof;
    assign bus.pk_out_eol   = st_reg.out_eol;
    assign bus.pk_out_eof   = st_reg.out_eof;
    assign width_err        = st_reg.width_err;
    assign height_err       = st_reg.height_err;
    assign mask_err         = st_reg.mask_err;
    assign ovf_err          = st_reg.ovf_err;
endmodule

// File: tb/tb_slice_pix_packer.sv
// Directed bench for slice_pix_packer: expected words are queued as beats are driven and
// popped as packed words appear.
module tb_slice_pix_packer;
    localparam int PW  = 14;
    localparam int PXW = 3 * PW;
    localparam int CW  = 16;

    logic          clk_out_int = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] line_width, frame_height;
    logic          width_err, height_err, mask_err, ovf_err;

    slice_pix_packer_if #(.PIX_WIDTH(PW)) bus ();

    slice_pix_packer #(.PIX_WIDTH(PW), .CNT_W(CW)) dut (
        .clk_out_int  (clk_out_int),
        .rst_n        (rst_n),
        .flush        (flush),
        .line_width   (line_width),
        .frame_height (frame_height),
        .bus          (bus),
        .width_err    (width_err),
        .height_err   (height_err),
        .mask_err     (mask_err),
        .ovf_err      (ovf_err)
    );

    always #5 clk_out_int = ~clk_out_int;

    typedef struct {
        logic [4*PXW-1:0] data;
        logic [3:0]       valid;
        logic             eol;
        logic             eof;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [PXW-1:0] pxv(input int id);
        logic [PW-1:0] a;
        a = PW'(id);
        return {a + 14'd7, a ^ 14'h2A5, a};
    endfunction

    task automatic chk(input string tag, input logic [4*PXW-1:0] obs, input logic [4*PXW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Queue a word made of pixels a..d, of which the first n are valid.
    task automatic push(input int a, input int b, input int c, input int d,
                        input int n, input logic eol, input logic eof);
        exp_t e;
        int   ids[4];
        ids = '{a, b, c, d};
        e.data = '0;
        e.valid = '0;
        for (int l = 0; l < 4; l++) begin
            if (l < n) begin
                e.data[l*PXW +: PXW] = pxv(ids[l]);
                e.valid[l] = 1'b1;
            end
        end
        e.eol = eol;
        e.eof = eof;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input logic exp_sof);
        exp_t             e;
        logic [4*PXW-1:0] lane_mask;
        chk("sof_pulse", 168'(bus.pk_out_sof), 168'(exp_sof));
        if (bus.pk_out_valid !== 4'b0000 || bus.pk_out_eol !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 168'({bus.pk_out_valid, bus.pk_out_eol}), 168'(0));
            end else begin
                e = exp_q.pop_front();
                lane_mask = '0;
                for (int l = 0; l < 4; l++)
                    if (e.valid[l]) lane_mask[l*PXW +: PXW] = '1;
                chk("word_valid", 168'(bus.pk_out_valid), 168'(e.valid));
                chk("word_eol", 168'(bus.pk_out_eol), 168'(e.eol));
                chk("word_eof", 168'(bus.pk_out_eof), 168'(e.eof));
                chk("word_data", bus.pk_out & lane_mask, e.data);
            end
        end
    endtask

    // One clock: drive a beat whose lane l carries pixel id+l, then check what emerged.
    task automatic step(input int id, input logic [3:0] m, input logic eol,
                        input logic eof, input logic sof);
        bus.pixs_in       = {pxv(id + 3), pxv(id + 2), pxv(id + 1), pxv(id)};
        bus.pixs_in_valid = m;
        bus.pixs_in_eol   = eol;
        bus.pixs_in_eof   = eof;
        bus.pixs_in_sof   = sof;
        @(posedge clk_out_int);
        #1;
        check_out(sof);
    endtask

    task automatic drained(input string tag);
        chk(tag, 168'(exp_q.size()), 168'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        line_width = 16'd10;
        frame_height = 16'd2;
        bus.pixs_in = '0;
        bus.pixs_in_valid = '0;
        bus.pixs_in_sof = 1'b0;
        bus.pixs_in_eol = 1'b0;
        bus.pixs_in_eof = 1'b0;
        repeat (2) @(posedge clk_out_int);
        #1;
        chk("rst_valid", 168'(bus.pk_out_valid), 168'(0));
        chk("rst_eol", 168'({bus.pk_out_sof, bus.pk_out_eol, bus.pk_out_eof}), 168'(0));
        chk("rst_errs", 168'({width_err, height_err, mask_err, ovf_err}), 168'(0));
        rst_n = 1'b1;

        // Line of 10 pixels with a partial last beat.
        step(0, 4'b0000, 0, 0, 1);
        push(100, 101, 102, 103, 4, 0, 0); step(100, 4'b1111, 0, 0, 0);
        push(110, 111, 112, 113, 4, 0, 0); step(110, 4'b1111, 0, 0, 0);
        push(120, 121, 0, 0, 2, 1, 0);     step(120, 4'b0011, 1, 0, 0);
        step(0, 4'b0000, 0, 0, 0);
        drained("s1_drained");
        chk("s1_errs", 168'({width_err, height_err, mask_err, ovf_err}), 168'(0));

        // Line of 16 with a 3-lane bubble mid-line.
        line_width = 16'd16;
        step(0, 4'b0000, 0, 0, 1);
        push(200, 201, 202, 203, 4, 0, 0); step(200, 4'b1111, 0, 0, 0);
        step(210, 4'b0111, 0, 0, 0);
        push(210, 211, 212, 220, 4, 0, 0); step(220, 4'b1111, 0, 0, 0);
        push(221, 222, 223, 230, 4, 0, 0); step(230, 4'b1111, 0, 0, 0);
        push(231, 232, 233, 240, 4, 1, 0); step(240, 4'b0001, 1, 0, 0);
        drained("s2_drained");
        chk("s2_width_err", 168'(width_err), 168'(0));

        // Line end needing a flush cycle; the beat arriving in it comes out one cycle late.
        line_width = 16'd7;
        step(0, 4'b0000, 0, 0, 1);
        step(300, 4'b0111, 0, 0, 0);
        push(300, 301, 302, 310, 4, 0, 0); step(310, 4'b1111, 1, 0, 0);
        push(311, 312, 313, 0, 3, 1, 0);   step(320, 4'b1111, 0, 0, 0);
        push(320, 321, 322, 323, 4, 0, 0); step(0, 4'b0000, 0, 0, 0);
        push(330, 331, 332, 0, 3, 1, 0);   step(330, 4'b0111, 1, 0, 0);
        drained("s3_drained");
        chk("s3_width_err", 168'(width_err), 168'(0));
        chk("s3_ovf_err", 168'(ovf_err), 168'(0));

        // Back-to-back stalls with the hold register busy: one beat is dropped.
        step(0, 4'b0000, 0, 0, 1);
        step(400, 4'b0111, 0, 0, 0);
        push(400, 401, 402, 410, 4, 0, 0); step(410, 4'b1111, 1, 0, 0);
        push(411, 412, 413, 0, 3, 1, 0);   step(420, 4'b0111, 0, 0, 0);
        step(430, 4'b1111, 1, 0, 0);
        push(420, 421, 422, 430, 4, 0, 0); step(440, 4'b1111, 0, 0, 0);
        push(431, 432, 433, 0, 3, 1, 0);   step(450, 4'b0001, 0, 0, 0);
        chk("s4_ovf_set", 168'(ovf_err), 168'(1));
        push(440, 441, 442, 443, 4, 0, 0); step(0, 4'b0000, 0, 0, 0);
        push(0, 0, 0, 0, 0, 1, 0);         step(0, 4'b0000, 1, 0, 0);
        drained("s4_drained");
        chk("s4_width_err", 168'(width_err), 168'(1));
        chk("s4_ovf_sticky", 168'(ovf_err), 168'(1));

        // Frame geometry: correct height, then one line too few.
        line_width = 16'd4;
        frame_height = 16'd2;
        step(0, 4'b0000, 0, 0, 1);
        chk("s5_sof_clears", 168'({width_err, ovf_err}), 168'(0));
        push(500, 501, 502, 503, 4, 1, 0); step(500, 4'b1111, 1, 0, 0);
        push(510, 511, 512, 513, 4, 1, 1); step(510, 4'b1111, 1, 1, 0);
        chk("s5_height_ok", 168'(height_err), 168'(0));
        frame_height = 16'd3;
        step(0, 4'b0000, 0, 0, 1);
        push(520, 521, 522, 523, 4, 1, 0); step(520, 4'b1111, 1, 0, 0);
        push(530, 531, 532, 533, 4, 1, 1); step(530, 4'b1111, 1, 1, 0);
        chk("s5_height_err", 168'(height_err), 168'(1));
        chk("s5_width_ok", 168'(width_err), 168'(0));

        // Non-thermometer mask keeps only lane 0.
        line_width = 16'd1;
        step(0, 4'b0000, 0, 0, 1);
        step(600, 4'b0101, 0, 0, 0);
        chk("s6_mask_err", 168'(mask_err), 168'(1));
        push(600, 0, 0, 0, 1, 1, 0); step(0, 4'b0000, 1, 0, 0);
        chk("s6_width_ok", 168'(width_err), 168'(0));
        step(0, 4'b0000, 0, 0, 1);
        chk("s6_sof_clears", 168'(mask_err), 168'(0));

        // Flush mid-line discards the residual and clears the flags.
        line_width = 16'd4;
        step(700, 4'b0011, 0, 0, 0);
        step(710, 4'b0101, 0, 0, 0);
        chk("s7_mask_err", 168'(mask_err), 168'(1));
        flush = 1'b1;
        step(0, 4'b0000, 0, 0, 0);
        flush = 1'b0;
        chk("s7_flush_errs", 168'({width_err, height_err, mask_err, ovf_err}), 168'(0));
        chk("s7_flush_valid", 168'(bus.pk_out_valid), 168'(0));
        step(0, 4'b0000, 0, 0, 1);
        push(720, 721, 722, 723, 4, 0, 0); step(720, 4'b1111, 0, 0, 0);
        push(0, 0, 0, 0, 0, 1, 0);         step(0, 4'b0000, 1, 0, 0);
        chk("s7_width_ok", 168'(width_err), 168'(0));

        // Asynchronous reset clears a word already on the output.
        push(740, 741, 742, 743, 4, 0, 0); step(740, 4'b1111, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 168'(bus.pk_out_valid), 168'(0));
        @(posedge clk_out_int);
        #1 rst_n = 1'b1;
        step(0, 4'b0000, 0, 0, 1);
        push(750, 751, 752, 753, 4, 1, 0); step(750, 4'b1111, 1, 0, 0);
        step(0, 4'b0000, 0, 0, 0);
        drained("final_drained");
        chk("final_errs", 168'({width_err, height_err, mask_err, ovf_err}), 168'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
